// File: rtl/draw_source_scheduler.sv
// draw_source_scheduler
// Per-frame sequencer for the shared draw-manager write bus. On each frame
// pulse the sources 0..NUM_SOURCES-1 are granted the bus in order. While a
// source holds write_active its pixels are registered onto the framebuffer
// write port. A source that never answers its grant is skipped after
// TIMEOUT_CYCLES and flagged in the sticky source_timeout vector.
//
// Optional build feature: define DRAW_SOURCE_MASK_EN to add the
// source_enable input. A disabled source spends one cycle in GRANT with
// write_awaited low and then one cycle in NEXT, without counting a timeout.
// source_enable is sampled each time GRANT is entered.
module draw_source_scheduler #(
  parameter int NUM_SOURCES       = 4,
  parameter int SOURCE_SEL_ADDRW  = 2,
  parameter int COLOR_DEPTH       = 9,
  parameter int DRAW_WIDTH_ADDRW  = 9,
  parameter int DRAW_HEIGHT_ADDRW = 8,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame,
  output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
  output logic                         write_awaited,
  input  logic                         write_active,
  input  logic [COLOR_DEPTH-1:0]       write_color_data,
  input  logic                         write_transparent,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
  output logic                         fb_we,
  output logic [DRAW_WIDTH_ADDRW-1:0]  fb_x,
  output logic [DRAW_HEIGHT_ADDRW-1:0] fb_y,
  output logic [COLOR_DEPTH-1:0]       fb_data,
  output logic                         busy,
  output logic                         draw_done,
  output logic                         frame_overrun,
  output logic [NUM_SOURCES-1:0]       source_timeout
`ifdef DRAW_SOURCE_MASK_EN
  ,
  input  logic [NUM_SOURCES-1:0]       source_enable
`endif
);

  // Counter must hold TIMEOUT_CYCLES itself without wrapping.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SOURCE_SEL_ADDRW-1:0] SEL_LAST = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
  localparam logic [SOURCE_SEL_ADDRW-1:0] SEL_ZERO = SOURCE_SEL_ADDRW'(0);
  localparam logic [SOURCE_SEL_ADDRW-1:0] SEL_ONE  = SOURCE_SEL_ADDRW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_DRAW  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                        state_r;
  logic [SOURCE_SEL_ADDRW-1:0]   sel_r;
  logic [CNT_W-1:0]              cnt_r;
  logic                          awaited_r;
  logic                          grant_en_r;
  logic                          busy_r;
  logic                          draw_done_r;
  logic                          frame_overrun_r;
  logic [NUM_SOURCES-1:0]        source_timeout_r;
  logic                          fb_we_r;
  logic [DRAW_WIDTH_ADDRW-1:0]   fb_x_r;
  logic [DRAW_HEIGHT_ADDRW-1:0]  fb_y_r;
  logic [COLOR_DEPTH-1:0]        fb_data_r;

  logic [SOURCE_SEL_ADDRW-1:0]   sel_nxt_s;
  logic                          en_first_s;
  logic                          en_next_s;
  logic                          capture_s;

  assign sel_nxt_s = sel_r + SEL_ONE;

`ifdef DRAW_SOURCE_MASK_EN
  // Enable bit of source 0 (new pass) and of the following source (NEXT).
  always_comb begin
    en_first_s = source_enable[0];
    en_next_s  = source_enable[sel_nxt_s];
  end
`else
  // Without the mask every source is always granted.
  always_comb begin
    en_first_s = 1'b1;
    en_next_s  = 1'b1;
  end
`endif

  // Pixel capture: only an opaque pixel from a granted, enabled source.
  always_comb begin
    capture_s = 1'b0;
    if (((state_r == ST_GRANT) && grant_en_r) || (state_r == ST_DRAW)) begin
      capture_s = write_active && !write_transparent;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Sequencer FSM with registered bus-grant and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      sel_r            <= SEL_ZERO;
      cnt_r            <= CNT_ZERO;
      awaited_r        <= 1'b0;
      grant_en_r       <= 1'b0;
      busy_r           <= 1'b0;
      draw_done_r      <= 1'b0;
      frame_overrun_r  <= 1'b0;
      source_timeout_r <= {NUM_SOURCES{1'b0}};
    end else begin
      draw_done_r     <= 1'b0;
      frame_overrun_r <= 1'b0;
      if (frame && busy_r) begin
        // Restart the pass from source 0; the running source is abandoned.
        frame_overrun_r <= 1'b1;
        state_r         <= ST_GRANT;
        sel_r           <= SEL_ZERO;
        cnt_r           <= CNT_ZERO;
        awaited_r       <= en_first_s;
        grant_en_r      <= en_first_s;
        busy_r          <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (frame) begin
              state_r    <= ST_GRANT;
              sel_r      <= SEL_ZERO;
              cnt_r      <= CNT_ZERO;
              awaited_r  <= en_first_s;
              grant_en_r <= en_first_s;
              busy_r     <= 1'b1;
            end else begin
              state_r    <= ST_IDLE;
              sel_r      <= SEL_ZERO;
              awaited_r  <= 1'b0;
              busy_r     <= 1'b0;
            end
          end
          ST_GRANT: begin
            if (!grant_en_r) begin
              state_r   <= ST_NEXT;
              awaited_r <= 1'b0;
            end else if (write_active) begin
              state_r                 <= ST_DRAW;
              awaited_r               <= 1'b0;
              source_timeout_r[sel_r] <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
              state_r                 <= ST_NEXT;
              awaited_r               <= 1'b0;
              source_timeout_r[sel_r] <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_DRAW: begin
            if (!write_active) begin
              state_r <= ST_NEXT;
            end else begin
              state_r <= ST_DRAW;
            end
          end
          ST_NEXT: begin
            cnt_r <= CNT_ZERO;
            if (sel_r == SEL_LAST) begin
              state_r     <= ST_DONE;
              busy_r      <= 1'b0;
              draw_done_r <= 1'b1;
            end else begin
              state_r    <= ST_GRANT;
              sel_r      <= sel_nxt_s;
              awaited_r  <= en_next_s;
              grant_en_r <= en_next_s;
            end
          end
          ST_DONE: begin
            if (frame) begin
              // Back-to-back pass: not an overrun since the pass just ended.
              state_r    <= ST_GRANT;
              sel_r      <= SEL_ZERO;
              cnt_r      <= CNT_ZERO;
              awaited_r  <= en_first_s;
              grant_en_r <= en_first_s;
              busy_r     <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              sel_r   <= SEL_ZERO;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            sel_r     <= SEL_ZERO;
            cnt_r     <= CNT_ZERO;
            awaited_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Framebuffer write port: one-cycle registered copy of captured pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we_r   <= 1'b0;
      fb_x_r    <= {DRAW_WIDTH_ADDRW{1'b0}};
      fb_y_r    <= {DRAW_HEIGHT_ADDRW{1'b0}};
      fb_data_r <= {COLOR_DEPTH{1'b0}};
    end else begin
      fb_we_r <= capture_s;
      if (capture_s) begin
        fb_x_r    <= write_x_addr;
        fb_y_r    <= write_y_addr;
        fb_data_r <= write_color_data;
      end else begin
        fb_x_r    <= fb_x_r;
        fb_y_r    <= fb_y_r;
        fb_data_r <= fb_data_r;
      end
    end
  end

  assign write_source_sel = sel_r;
  assign write_awaited    = awaited_r;
  assign busy             = busy_r;
  assign draw_done        = draw_done_r;
  assign frame_overrun    = frame_overrun_r;
  assign source_timeout   = source_timeout_r;
  assign fb_we            = fb_we_r;
  assign fb_x             = fb_x_r;
  assign fb_y             = fb_y_r;
  assign fb_data          = fb_data_r;

endmodule

// File: tb/tb_draw_source_scheduler.sv
// Self-checking bench for draw_source_scheduler (TIMEOUT_CYCLES=16).
// Table of whole-pass vectors plus hand-written reset, abort and mask
// sequences; every opaque bus pixel is pushed to a scoreboard queue and
// popped when fb_we appears.
module tb_draw_source_scheduler;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int CD = 9;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          frame;
  logic [SW-1:0] write_source_sel;
  logic          write_awaited;
  logic          write_active;
  logic [CD-1:0] write_color_data;
  logic          write_transparent;
  logic [XW-1:0] write_x_addr;
  logic [YW-1:0] write_y_addr;
  logic          fb_we;
  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;
  logic [CD-1:0] fb_data;
  logic          busy;
  logic          draw_done;
  logic          frame_overrun;
  logic [N-1:0]  source_timeout;
`ifdef DRAW_SOURCE_MASK_EN
  logic [N-1:0]  source_enable;
`endif

  draw_source_scheduler #(
    .NUM_SOURCES(N), .SOURCE_SEL_ADDRW(SW), .COLOR_DEPTH(CD),
    .DRAW_WIDTH_ADDRW(XW), .DRAW_HEIGHT_ADDRW(YW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame),
    .write_source_sel(write_source_sel), .write_awaited(write_awaited),
    .write_active(write_active), .write_color_data(write_color_data),
    .write_transparent(write_transparent), .write_x_addr(write_x_addr),
    .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_data(fb_data), .busy(busy), .draw_done(draw_done),
    .frame_overrun(frame_overrun), .source_timeout(source_timeout)
`ifdef DRAW_SOURCE_MASK_EN
    , .source_enable(source_enable)
`endif
  );

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CD-1:0] d;
    int            stamp;
  } pix_t;

  typedef struct {
    int           npix0;
    logic [7:0]   tmask0;
    int           npix;
    logic [N-1:0] silent;
    int           exp_writes;
    logic [N-1:0] exp_to;
  } vec_t;

  pix_t         sb_q[$];
  pix_t         e;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  int           wr_cnt = 0;
  int           done_cnt = 0;
  int           ovr_cnt = 0;
  logic [N-1:0] aw_seen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: scoreboard pops and event counters.
  always @(negedge clk) begin
    if (draw_done === 1'b1) done_cnt++;
    if (frame_overrun === 1'b1) ovr_cnt++;
    if (write_awaited === 1'b1) aw_seen[write_source_sel] = 1'b1;
    if (fb_we === 1'b1) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fb_unexpected: got write x=%0h y=%0h d=%0h expected none", fb_x, fb_y, fb_data);
      end else begin
        e = sb_q.pop_front();
        check("fb_x", 32'(fb_x), 32'(e.x));
        check("fb_y", 32'(fb_y), 32'(e.y));
        check("fb_data", 32'(fb_data), 32'(e.d));
        check("fb_latency", cyc, e.stamp + 1);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    write_active      = 1'b0;
    write_transparent = 1'b0;
    write_x_addr      = 'x;
    write_y_addr      = 'x;
    write_color_data  = 'x;
  endtask

  task automatic drive_pix(input int s, input int i, input logic transp);
    write_active      = 1'b1;
    write_transparent = transp;
    write_x_addr      = XW'(s * 64 + i + 1);
    write_y_addr      = YW'(s * 16 + i + 3);
    write_color_data  = CD'($urandom_range(0, 511));
    if (!transp) sb_q.push_back('{write_x_addr, write_y_addr, write_color_data, cyc});
    step();
  endtask

  task automatic wait_grant(input int s, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < TO + 8; k++) begin
      if (write_awaited === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("grant_seen", 32'(ok), 32'd1);
    if (ok) check("grant_sel", 32'(write_source_sel), 32'(s));
  endtask

  task automatic serve(input int s, input int npix, input logic silent, input logic [7:0] tmask);
    bit ok;
    int n;
    wait_grant(s, ok);
    if (ok) begin
      if (silent) begin
        n = 0;
        while (write_awaited === 1'b1 && n < TO + 8) begin
          n++;
          step();
        end
        check("grant_len", n, TO);
      end else begin
        step();
        step();
        for (int i = 0; i < npix; i++) drive_pix(s, i, tmask[i]);
        bus_idle();
      end
    end
  endtask

  task automatic start_frame;
    frame = 1'b1;
    step();
    frame = 1'b0;
  endtask

  task automatic finish_pass;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (draw_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("done_seen", 32'(ok), 32'd1);
    step();
    check("busy_after", 32'(busy), 32'd0);
    check("sb_empty", sb_q.size(), 0);
  endtask

  vec_t vecs[3];

  initial begin
    int w0, d0, o0, c0, e1;
    bit ok;
    vecs[0] = '{3, 8'h00, 3, 4'b0000, 12, 4'b0000};
    vecs[1] = '{5, 8'b0000_1010, 3, 4'b0000, 12, 4'b0000};
    vecs[2] = '{3, 8'h00, 3, 4'b0010, 9, 4'b0010};

    rst = 1'b1;
    frame = 1'b0;
    aw_seen = '0;
    bus_idle();
`ifdef DRAW_SOURCE_MASK_EN
    source_enable = 4'b1111;
`endif
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_awaited", 32'(write_awaited), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_timeout", 32'(source_timeout), 32'd0);
    rst = 1'b0;
    step();

    // Whole-pass vectors.
    for (int v = 0; v < 3; v++) begin
      w0 = wr_cnt;
      d0 = done_cnt;
      o0 = ovr_cnt;
      start_frame();
      for (int s = 0; s < N; s++)
        serve(s, (s == 0) ? vecs[v].npix0 : vecs[v].npix, vecs[v].silent[s],
              (s == 0) ? vecs[v].tmask0 : 8'h00);
      finish_pass();
      check("vec_writes", wr_cnt - w0, vecs[v].exp_writes);
      check("vec_timeout", 32'(source_timeout), 32'(vecs[v].exp_to));
      check("vec_done_once", done_cnt - d0, 1);
      check("vec_no_overrun", ovr_cnt - o0, 0);
      step();
    end

    // Reset in the middle of source 0's DRAW.
    start_frame();
    wait_grant(0, ok);
    step();
    step();
    drive_pix(0, 0, 1'b0);
    rst = 1'b1;
    write_active = 1'b1;
    write_x_addr = 9'h1AB;
    write_y_addr = 8'h5C;
    write_color_data = 9'h155;
    step();
    rst = 1'b0;
    bus_idle();
    check("mrst_fb_we", 32'(fb_we), 32'd0);
    check("mrst_fb_x", 32'(fb_x), 32'd0);
    check("mrst_fb_y", 32'(fb_y), 32'd0);
    check("mrst_fb_data", 32'(fb_data), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_awaited", 32'(write_awaited), 32'd0);
    check("mrst_sel", 32'(write_source_sel), 32'd0);
    check("mrst_done", 32'(draw_done), 32'd0);
    check("mrst_overrun", 32'(frame_overrun), 32'd0);
    check("mrst_timeout", 32'(source_timeout), 32'd0);
    step();
    step();
    check("mrst_idle", 32'(busy), 32'd0);
    w0 = wr_cnt;
    start_frame();
    for (int s = 0; s < N; s++) serve(s, 3, 1'b0, 8'h00);
    finish_pass();
    check("mrst_clean_writes", wr_cnt - w0, 12);
    step();

    // Frame arrives while source 2 is drawing.
    w0 = wr_cnt;
    o0 = ovr_cnt;
    start_frame();
    serve(0, 3, 1'b0, 8'h00);
    serve(1, 3, 1'b0, 8'h00);
    wait_grant(2, ok);
    step();
    step();
    drive_pix(2, 0, 1'b0);
    drive_pix(2, 1, 1'b0);
    frame = 1'b1;
    write_active = 1'b1;
    write_transparent = 1'b1;
    step();
    frame = 1'b0;
    bus_idle();
    check("abort_overrun", 32'(frame_overrun), 32'd1);
    check("abort_sel", 32'(write_source_sel), 32'd0);
    check("abort_awaited", 32'(write_awaited), 32'd1);
    check("abort_busy", 32'(busy), 32'd1);
    for (int s = 0; s < N; s++) serve(s, 3, 1'b0, 8'h00);
    finish_pass();
    check("abort_writes", wr_cnt - w0, 6 + 2 + 12);
    check("abort_ovr_once", ovr_cnt - o0, 1);
    step();

`ifdef DRAW_SOURCE_MASK_EN
    // Only sources 1 and 3 enabled.
    source_enable = 4'b1010;
    aw_seen = '0;
    w0 = wr_cnt;
    c0 = cyc;
    start_frame();
    wait_grant(1, ok);
    check("mask_grant1_cyc", cyc, c0 + 3);
    step();
    step();
    for (int i = 0; i < 3; i++) drive_pix(1, i, 1'b0);
    bus_idle();
    e1 = cyc;
    wait_grant(3, ok);
    check("mask_grant3_cyc", cyc, e1 + 4);
    step();
    step();
    for (int i = 0; i < 3; i++) drive_pix(3, i, 1'b0);
    bus_idle();
    finish_pass();
    check("mask_awaited_set", 32'(aw_seen), 32'b1010);
    check("mask_timeout", 32'(source_timeout), 32'd0);
    check("mask_writes", wr_cnt - w0, 6);
    source_enable = 4'b1111;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
